seq_scan_sched: RTL and testbench

SEQ_SCAN_SCHED -- requirements
Module: seq_scan_sched

---
 rtl/seq_scan_sched_pkg.sv | 16 +
 rtl/seq_scan_sched_if.sv | 23 ++
 rtl/seq_step.sv | 34 +++
 rtl/seq_scan_sched.sv | 82 ++++++++
 tb/tb_seq_scan_sched.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/seq_scan_sched_pkg.sv
// Shared constants for the two-requester sequence scanner.
package seq_scan_sched_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  // Pointer value after reset/clear: "requester 1 went last", so requester 0 wins the first tie.
  localparam logic LAST_RST = 1'b1;

endpackage

// File: rtl/seq_scan_sched_if.sv
// Requester handshakes and match reporting for seq_scan_sched.
interface seq_scan_sched_if #(parameter int CNT_W = 8);
  logic             req0_valid;
  logic [1:0]       req0_sym;
  logic             req0_ready;
  logic             req1_valid;
  logic [1:0]       req1_sym;
  logic             req1_ready;
  logic             hit_valid;
  logic             hit_id;
  logic [CNT_W-1:0] hit_cnt0;
  logic [CNT_W-1:0] hit_cnt1;

  modport master (
    output req0_valid, req0_sym, req1_valid, req1_sym,
    input  req0_ready, req1_ready, hit_valid, hit_id, hit_cnt0, hit_cnt1
  );

  modport slave (
    input  req0_valid, req0_sym, req1_valid, req1_sym,
    output req0_ready, req1_ready, hit_valid, hit_id, hit_cnt0, hit_cnt1
  );
endinterface

// File: rtl/seq_step.sv
// Detector step function: one symbol applied to one context.
// match flags a step that lands in S3; the caller handles the restart.
module seq_step
  import seq_scan_sched_pkg::*;
(
  input  state_t     state,
  input  logic [1:0] sym,
  output state_t     next,
  output logic       match
);

  // Next-state table; unlisted symbols keep the current state.
  always_comb begin
    next = state;
    case (state)
      S0: if (sym == 2'b01) next = S1;
      S1: begin
        if (sym == 2'b10)      next = S2;
        else if (sym == 2'b11) next = S0;
      end
      S2: begin
        case (sym)
          2'b01:   next = S1;
          2'b10:   next = S0;
          2'b11:   next = S3;
          default: next = S2;
        endcase
      end
      default: next = S0; // S3 is never held; treat as restart
    endcase
    match = (next == S3);
  end

endmodule

// File: rtl/seq_scan_sched.sv
// Two requesters share one seq_step through a round-robin grant.
// Each requester keeps its own context and saturating match counter.
module seq_scan_sched
  import seq_scan_sched_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  seq_scan_sched_if.slave bus
);

  state_t                            ctx [NUM_REQ];
  logic [NUM_REQ-1:0][CNT_W-1:0]     cnt;
  logic                              last;
  logic                              hv;
  logic                              hid;
  logic                              g0, g1, xfer, owner;
  state_t                            cur, nxt;
  logic [1:0]                        sym_sel;
  logic                              mt;

  // Round-robin grant; clr blocks every transfer.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!clr) begin
      g0 = bus.req0_valid && (!bus.req1_valid || last == 1'b1);
      g1 = bus.req1_valid && (!bus.req0_valid || last == 1'b0);
    end
  end

  assign xfer    = g0 | g1;
  assign owner   = g1;
  assign cur     = owner ? ctx[1] : ctx[0];
  assign sym_sel = owner ? bus.req1_sym : bus.req0_sym;

  seq_step u_step (
    .state (cur),
    .sym   (sym_sel),
    .next  (nxt),
    .match (mt)
  );

  // Contexts, counters, pointer and hit pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctx[0] <= S0;
      ctx[1] <= S0;
      cnt    <= '0;
      last   <= LAST_RST;
      hv     <= 1'b0;
      hid    <= 1'b0;
    end else if (clr) begin
      ctx[0] <= S0;
      ctx[1] <= S0;
      cnt    <= '0;
      last   <= LAST_RST;
      hv     <= 1'b0;
    end else begin
      hv <= 1'b0;
      if (xfer) begin
        last       <= owner;
        ctx[owner] <= mt ? S0 : nxt;
        if (mt) begin
          hv  <= 1'b1;
          hid <= owner;
          if (cnt[owner] != {CNT_W{1'b1}}) cnt[owner] <= cnt[owner] + 1'b1;
        end
      end
    end
  end

  assign bus.req0_ready = g0;
  assign bus.req1_ready = g1;
  assign bus.hit_valid  = hv;
  assign bus.hit_id     = hid;
  assign bus.hit_cnt0   = cnt[0];
  assign bus.hit_cnt1   = cnt[1];

endmodule

// File: tb/tb_seq_scan_sched.sv
// Directed bench for seq_scan_sched (2-bit counters to reach saturation quickly).
module tb_seq_scan_sched;

  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clr = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  seq_scan_sched_if #(.CNT_W(CW)) bus ();

  seq_scan_sched #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check readies mid-cycle, check registered hit after the edge.
  task automatic cyc(input string tag, input logic c,
                     input logic v0, input logic [1:0] s0,
                     input logic v1, input logic [1:0] s1,
                     input logic er0, input logic er1,
                     input logic ehv, input logic ehid);
    clr = c;
    bus.req0_valid = v0; bus.req0_sym = s0;
    bus.req1_valid = v1; bus.req1_sym = s1;
    @(negedge clk);
    chk({tag, ".ready0"}, 32'(bus.req0_ready), 32'(er0));
    chk({tag, ".ready1"}, 32'(bus.req1_ready), 32'(er1));
    @(posedge clk); #1;
    chk({tag, ".hit_valid"}, 32'(bus.hit_valid), 32'(ehv));
    chk({tag, ".hit_id"}, 32'(bus.hit_id), 32'(ehid));
  endtask

  task automatic cnts(input string tag, input int e0, input int e1);
    chk({tag, ".cnt0"}, 32'(bus.hit_cnt0), 32'(e0));
    chk({tag, ".cnt1"}, 32'(bus.hit_cnt1), 32'(e1));
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_sym = 2'b00;
    bus.req1_valid = 1'b0; bus.req1_sym = 2'b00;

    // Reset state
    #12;
    chk("rst.hit_valid", 32'(bus.hit_valid), 0);
    chk("rst.hit_id", 32'(bus.hit_id), 0);
    cnts("rst", 0, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Req0 alone: 01,10,11 -> hit id 0
    cyc("a1", 0, 1, 2'b01, 0, 2'b00, 1, 0, 0, 0);
    cyc("a2", 0, 1, 2'b10, 0, 2'b00, 1, 0, 0, 0);
    cyc("a3", 0, 1, 2'b11, 0, 2'b00, 1, 0, 1, 0);
    cnts("a", 1, 0);
    cyc("a4", 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0);

    // Both valid: clear pointer, then grants alternate 0,1,0,1,0,1
    cyc("b0", 1, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    cnts("b0", 0, 0);
    cyc("b1", 0, 1, 2'b01, 1, 2'b01, 1, 0, 0, 0);
    cyc("b2", 0, 1, 2'b10, 1, 2'b01, 0, 1, 0, 0);
    cyc("b3", 0, 1, 2'b10, 1, 2'b10, 1, 0, 0, 0);
    cyc("b4", 0, 1, 2'b11, 1, 2'b10, 0, 1, 0, 0);
    cyc("b5", 0, 1, 2'b11, 1, 2'b11, 1, 0, 1, 0);
    cyc("b6", 0, 0, 2'b00, 1, 2'b11, 0, 1, 1, 1);
    cyc("b7", 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 1);
    cnts("b", 1, 1);

    // Interleave: req0 context survives req1 traffic
    cyc("c0", 1, 0, 2'b00, 0, 2'b00, 0, 0, 0, 1);
    cyc("c1", 0, 1, 2'b01, 0, 2'b00, 1, 0, 0, 1);
    cyc("c2", 0, 1, 2'b10, 0, 2'b00, 1, 0, 0, 1);
    cyc("c3", 0, 0, 2'b00, 1, 2'b00, 0, 1, 0, 1);
    cyc("c4", 0, 0, 2'b00, 1, 2'b01, 0, 1, 0, 1);
    cyc("c5", 0, 1, 2'b11, 0, 2'b00, 1, 0, 1, 0);
    cnts("c", 1, 0);

    // Saturation: req1 completes five matches, counter caps at 3
    cyc("d0", 1, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc("d.01", 0, 0, 2'b00, 1, 2'b01, 0, 1, 0, (k == 0) ? 1'b0 : 1'b1);
      cyc("d.10", 0, 0, 2'b00, 1, 2'b10, 0, 1, 0, (k == 0) ? 1'b0 : 1'b1);
      cyc("d.11", 0, 0, 2'b00, 1, 2'b11, 0, 1, 1, 1);
      cnts("d", 0, (k + 1 > 3) ? 3 : k + 1);
    end

    // clr during a would-be completing transfer
    cyc("e0", 1, 0, 2'b00, 0, 2'b00, 0, 0, 0, 1);
    cyc("e1", 0, 1, 2'b01, 0, 2'b00, 1, 0, 0, 1);
    cyc("e2", 0, 1, 2'b10, 0, 2'b00, 1, 0, 0, 1);
    cyc("e3", 1, 1, 2'b11, 0, 2'b00, 0, 0, 0, 1);
    cyc("e4", 0, 1, 2'b11, 0, 2'b00, 1, 0, 0, 1);
    cnts("e", 0, 0);

    // Async reset mid-stream
    cyc("f1", 0, 1, 2'b01, 0, 2'b00, 1, 0, 0, 1);
    cyc("f2", 0, 1, 2'b10, 0, 2'b00, 1, 0, 0, 1);
    cyc("f3", 0, 1, 2'b11, 0, 2'b00, 1, 0, 1, 0);
    cnts("f3", 1, 0);
    cyc("f4", 0, 1, 2'b01, 0, 2'b00, 1, 0, 0, 0);
    cyc("f5", 0, 0, 2'b00, 1, 2'b11, 0, 1, 0, 0);
    cyc("f6", 0, 1, 2'b10, 0, 2'b00, 1, 0, 0, 0);
    cyc("f7", 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    // Make hit_id nonzero so the async clear is observable.
    cyc("f8", 0, 0, 2'b00, 1, 2'b01, 0, 1, 0, 0);
    cyc("f9", 0, 0, 2'b00, 1, 2'b10, 0, 1, 0, 0);
    cyc("fa", 0, 0, 2'b00, 1, 2'b11, 0, 1, 1, 1);
    cnts("fa", 1, 1);
    #2 reset = 1'b1;
    #1;
    chk("f.async.hit_valid", 32'(bus.hit_valid), 0);
    chk("f.async.hit_id", 32'(bus.hit_id), 0);
    cnts("f.async", 0, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    // req0 had 01,10 before reset; 11 now must not match.
    cyc("g1", 0, 1, 2'b11, 0, 2'b00, 1, 0, 0, 0);
    // Pointer back to reset value after req0's grant? No: last is now 0, so test tie from fresh reset.
    reset = 1'b1; #1; reset = 1'b0;
    cyc("g2", 0, 1, 2'b00, 1, 2'b00, 1, 0, 0, 0);
    cyc("g3", 0, 1, 2'b00, 1, 2'b00, 0, 1, 0, 0);
    cnts("g", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
